// File: rtl/usb_packet_tx_if.sv
// usb_packet_tx_if: request, payload and line bundle for the packet serializer.
// master = device core side, slave = usb_packet_tx.
interface usb_packet_tx_if;
    logic        checkData;
    logic        sendStart;
    logic [3:0]  sendPid;
    logic        sendHasData;
    logic [6:0]  sendLen;
    logic [7:0]  dataByte;
    logic        dataValid;
    logic        dataReady;
    logic        OE;
    logic        dPlus;
    logic        dMinus;
    logic        busy;
    logic        txDone;
    logic        txError;
    logic [15:0] crcOut;

    modport master (
        output checkData, sendStart, sendPid, sendHasData, sendLen,
        output dataByte, dataValid,
        input  dataReady, OE, dPlus, dMinus, busy, txDone, txError, crcOut
    );

    modport slave (
        input  checkData, sendStart, sendPid, sendHasData, sendLen,
        input  dataByte, dataValid,
        output dataReady, OE, dPlus, dMinus, busy, txDone, txError, crcOut
    );
endinterface

// File: rtl/usb_packet_tx.sv
// usb_packet_tx: full-speed USB packet serializer.
// SYNC, PID, payload and CRC16 with bit stuffing and NRZI, then EOP.
module usb_packet_tx (
    input  logic           useClk,
    input  logic           reset,
    usb_packet_tx_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC, EOP} txState_t;

    txState_t    state, stateNext;
    logic [3:0]  pidReg;
    logic        hasData;
    logic [6:0]  lenReg, accCnt, sentCnt;
    logic [7:0]  shiftReg, holdReg, loadVal;
    logic        holdFull;
    logic [2:0]  bitIdx, onesCnt;
    logic [1:0]  eopCnt;
    logic [15:0] crcReg, crcNext, crcFinal, crcOutReg;
    logic        crcHi, abortReg;
    logic        oeReg, dpReg, dmReg, busyReg, doneReg, errReg;
    logic        bitPhase, stuffNow, sendBit, lastBit, eopStep;
    logic        ready, xfer;
    logic        loadEn, takeHold, abort, enterCrc;

    assign bitPhase = (state == SYNC) || (state == PID) ||
                      (state == DATA) || (state == CRC);
    // A due stuff bit is still owed when the last field ends.
    assign stuffNow = bus.checkData && onesCnt == 3'd6 &&
                      (bitPhase || (state == EOP && eopCnt == 2'd0));
    assign sendBit  = bus.checkData && bitPhase && !stuffNow;
    assign lastBit  = sendBit && bitIdx == 3'd7;
    assign eopStep  = bus.checkData && state == EOP && !stuffNow;
    assign ready    = !holdFull && hasData && accCnt < lenReg &&
                      (state == PID || state == DATA);
    assign xfer     = ready && bus.dataValid;
    assign crcNext  = {1'b0, crcReg[15:1]} ^
                      ((crcReg[0] ^ shiftReg[0]) ? 16'hA001 : 16'h0000);
    assign crcFinal = (state == DATA) ? crcNext : crcReg;

    assign bus.dataReady = ready;
    assign bus.OE        = oeReg;
    assign bus.dPlus     = dpReg;
    assign bus.dMinus    = dmReg;
    assign bus.busy      = busyReg;
    assign bus.txDone    = doneReg;
    assign bus.txError   = errReg;
    assign bus.crcOut    = crcOutReg;

    // State register.
    always_ff @(posedge useClk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Next state and the byte to load at each byte boundary.
    always_comb begin
        stateNext = state;
        loadEn    = 1'b0;
        loadVal   = 8'h00;
        takeHold  = 1'b0;
        abort     = 1'b0;
        enterCrc  = 1'b0;
        unique case (state)
            IDLE: if (bus.sendStart) stateNext = SYNC;
            SYNC: if (lastBit) begin
                loadEn    = 1'b1;
                loadVal   = {~pidReg, pidReg};
                stateNext = PID;
            end
            PID: if (lastBit) begin
                if (!hasData) begin
                    stateNext = EOP;
                end else if (lenReg == 7'd0) begin
                    loadEn    = 1'b1;
                    loadVal   = ~crcFinal[7:0];
                    enterCrc  = 1'b1;
                    stateNext = CRC;
                end else if (holdFull) begin
                    loadEn    = 1'b1;
                    loadVal   = holdReg;
                    takeHold  = 1'b1;
                    stateNext = DATA;
                end else begin
                    abort     = 1'b1;
                    stateNext = EOP;
                end
            end
            DATA: if (lastBit) begin
                if (sentCnt + 7'd1 == lenReg) begin
                    loadEn    = 1'b1;
                    loadVal   = ~crcFinal[7:0];
                    enterCrc  = 1'b1;
                    stateNext = CRC;
                end else if (holdFull) begin
                    loadEn    = 1'b1;
                    loadVal   = holdReg;
                    takeHold  = 1'b1;
                end else begin
                    abort     = 1'b1;
                    stateNext = EOP;
                end
            end
            CRC: if (lastBit) begin
                if (!crcHi) begin
                    loadEn  = 1'b1;
                    loadVal = ~crcReg[15:8];
                end else begin
                    stateNext = EOP;
                end
            end
            EOP: if (eopStep && eopCnt == 2'd3) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Packet fields, payload buffering, bit engine and line drivers.
    always_ff @(posedge useClk) begin
        if (reset) begin
            pidReg    <= 4'h0;
            hasData   <= 1'b0;
            lenReg    <= 7'd0;
            accCnt    <= 7'd0;
            sentCnt   <= 7'd0;
            shiftReg  <= 8'h00;
            holdReg   <= 8'h00;
            holdFull  <= 1'b0;
            bitIdx    <= 3'd0;
            onesCnt   <= 3'd0;
            eopCnt    <= 2'd0;
            crcReg    <= 16'hFFFF;
            crcOutReg <= 16'h0000;
            crcHi     <= 1'b0;
            abortReg  <= 1'b0;
            oeReg     <= 1'b0;
            dpReg     <= 1'b1;
            dmReg     <= 1'b0;
            busyReg   <= 1'b0;
            doneReg   <= 1'b0;
            errReg    <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            errReg  <= 1'b0;
            if (state == IDLE && bus.sendStart) begin
                pidReg   <= bus.sendPid;
                hasData  <= bus.sendHasData;
                lenReg   <= bus.sendLen;
                accCnt   <= 7'd0;
                sentCnt  <= 7'd0;
                shiftReg <= 8'h80;
                holdFull <= 1'b0;
                bitIdx   <= 3'd0;
                onesCnt  <= 3'd0;
                eopCnt   <= 2'd0;
                crcReg   <= 16'hFFFF;
                crcHi    <= 1'b0;
                abortReg <= 1'b0;
                busyReg  <= 1'b1;
            end
            if (xfer) begin
                holdReg  <= bus.dataByte;
                holdFull <= 1'b1;
                accCnt   <= accCnt + 7'd1;
            end
            if (takeHold) holdFull <= 1'b0;
            if (stuffNow || (sendBit && !shiftReg[0])) begin
                dpReg <= dmReg;
                dmReg <= dpReg;
            end
            if (stuffNow) begin
                oeReg   <= 1'b1;
                onesCnt <= 3'd0;
            end
            if (sendBit) begin
                oeReg    <= 1'b1;
                onesCnt  <= shiftReg[0] ? onesCnt + 3'd1 : 3'd0;
                shiftReg <= loadEn ? loadVal : {1'b0, shiftReg[7:1]};
                bitIdx   <= bitIdx + 3'd1;
                if (state == DATA) crcReg <= crcNext;
                if (state == DATA && lastBit) sentCnt <= sentCnt + 7'd1;
                if (state == CRC && loadEn) crcHi <= 1'b1;
            end
            if (abort) abortReg <= 1'b1;
            if (enterCrc) crcOutReg <= ~crcFinal;
            if (eopStep) begin
                eopCnt <= eopCnt + 2'd1;
                unique case (eopCnt)
                    2'd0, 2'd1: begin
                        dpReg <= 1'b0;
                        dmReg <= 1'b0;
                    end
                    2'd2: begin
                        dpReg <= 1'b1;
                        dmReg <= 1'b0;
                    end
                    default: begin
                        oeReg   <= 1'b0;
                        busyReg <= 1'b0;
                        doneReg <= !abortReg;
                        errReg  <= abortReg;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_usb_packet_tx.sv
// tb_usb_packet_tx: scoreboard bench for usb_packet_tx.
// Expected line waveforms come from bit-list reference packets.
module tb_usb_packet_tx;
    logic useClk = 1'b0;
    logic reset  = 1'b1;

    usb_packet_tx_if bus ();

    usb_packet_tx dut (
        .useClk(useClk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 useClk = ~useClk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [1:0]  expSyms[$];
    int          expLen[$];
    bit          expErr[$];
    logic [15:0] expCrc[$];
    int          expXfer[$];
    logic [7:0]  payload[$];
    int          supplyLimit = 0;
    int          idx         = 0;
    int          xferCnt     = 0;
    bit          readySeen   = 1'b0;
    bit          xferPending = 1'b0;
    logic [15:0] lastCrc     = 16'h0000;
    int          doneCnt     = 0;
    int          errCnt      = 0;
    int          wantDone    = 0;
    int          wantErr     = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference packet: raw bits, then stuffing, then NRZI, then EOP.
    function automatic void buildPacket(input logic [3:0] pid,
                                        input int nBytes,
                                        input bit withCrc,
                                        output logic [15:0] crcVal);
        bit          raw[$];
        bit          stuffed[$];
        logic [7:0]  pidByte;
        logic [15:0] crc;
        logic [1:0]  lvl;
        int          ones;
        int          n;
        crc = 16'hFFFF;
        for (int i = 0; i < 7; i++) raw.push_back(1'b0);
        raw.push_back(1'b1);
        pidByte = {~pid, pid};
        for (int i = 0; i < 8; i++) raw.push_back(pidByte[i]);
        for (int b = 0; b < nBytes; b++) begin
            for (int i = 0; i < 8; i++) begin
                bit d;
                d = payload[b][i];
                raw.push_back(d);
                if (crc[0] ^ d) crc = (crc >> 1) ^ 16'hA001;
                else            crc = crc >> 1;
            end
        end
        crcVal = ~crc;
        if (withCrc) for (int i = 0; i < 16; i++) raw.push_back(crcVal[i]);
        ones = 0;
        foreach (raw[i]) begin
            stuffed.push_back(raw[i]);
            ones = raw[i] ? ones + 1 : 0;
            if (ones == 6) begin
                stuffed.push_back(1'b0);
                ones = 0;
            end
        end
        lvl = 2'b10;
        n   = 0;
        foreach (stuffed[i]) begin
            if (!stuffed[i]) lvl = {lvl[0], lvl[1]};
            expSyms.push_back(lvl);
            n++;
        end
        expSyms.push_back(2'b00);
        expSyms.push_back(2'b00);
        expSyms.push_back(2'b10);
        expLen.push_back(n + 3);
    endfunction

    task automatic startPacket(input logic [3:0] pid, input bit hasData,
                               input int len, input int limit,
                               input bit scored);
        logic [15:0] c;
        bit          err;
        int          sentN;
        err   = hasData && (limit < len);
        sentN = hasData ? (err ? limit : len) : 0;
        if (scored) begin
            buildPacket(pid, sentN, hasData && !err, c);
            if (hasData && !err) lastCrc = c;
            expErr.push_back(err);
            expCrc.push_back(lastCrc);
            expXfer.push_back(sentN);
            if (err) wantErr++;
            else     wantDone++;
        end
        idx         = 0;
        xferCnt     = 0;
        readySeen   = 1'b0;
        supplyLimit = hasData ? limit : 0;
        @(negedge useClk);
        bus.sendStart   = 1'b1;
        bus.sendPid     = pid;
        bus.sendHasData = hasData;
        bus.sendLen     = 7'(len);
        @(negedge useClk);
        bus.sendStart   = 1'b0;
        bus.sendPid     = 4'($urandom);
        bus.sendHasData = ~hasData;
        bus.sendLen     = 7'($urandom);
        check("busyRise", 32'(bus.busy), 32'd1);
    endtask

    task automatic waitIdle();
        int t;
        t = 0;
        while (bus.busy && t < 20000) begin
            @(negedge useClk);
            t++;
        end
        check("idleTimeout", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge useClk);
    endtask

    task automatic randPayload(input int n);
        payload.delete();
        for (int i = 0; i < n; i++)
            payload.push_back(($urandom % 4 == 0) ? 8'hFF : 8'($urandom));
    endtask

    // Bit-time strobe every third clock.
    initial begin
        int cnt;
        cnt = 0;
        bus.checkData = 1'b0;
        forever begin
            @(negedge useClk);
            cnt++;
            bus.checkData = (cnt % 3 == 0);
        end
    end

    // Payload source; counts handshakes seen before each rising edge.
    initial begin
        bus.dataValid = 1'b0;
        bus.dataByte  = 8'h00;
        forever begin
            @(negedge useClk);
            if (xferPending) begin
                idx++;
                xferCnt++;
            end
            bus.dataValid = (idx < supplyLimit);
            bus.dataByte  = bus.dataValid ? payload[idx] : 8'h00;
            #1;
            if (bus.dataReady) readySeen = 1'b1;
            xferPending = bus.dataValid && bus.dataReady && !reset;
        end
    end

    // Monitor: collect line symbols per strobe, score at packet end.
    initial begin
        logic [1:0]  acts[$];
        logic [1:0]  s;
        int          n;
        int          bad;
        int          x;
        bit          e;
        logic [15:0] c;
        forever begin
            @(posedge useClk);
            #1;
            if (reset) begin
                acts.delete();
                continue;
            end
            if (bus.checkData && bus.OE) acts.push_back({bus.dPlus, bus.dMinus});
            if (bus.txDone)  doneCnt++;
            if (bus.txError) errCnt++;
            if (bus.txDone || bus.txError) begin
                if (expLen.size() == 0) begin
                    check("unexpectedEnd", 32'd1, 32'd0);
                end else begin
                    n = expLen.pop_front();
                    e = expErr.pop_front();
                    c = expCrc.pop_front();
                    x = expXfer.pop_front();
                    check("strobeCount", acts.size(), n);
                    bad = -1;
                    for (int i = 0; i < n; i++) begin
                        s = expSyms.pop_front();
                        if (bad < 0 && (i >= acts.size() || acts[i] !== s)) bad = i;
                    end
                    check("lineSeqFirstBadIdx", bad, -1);
                    check("txError", 32'(bus.txError), 32'(e));
                    check("txDone", 32'(bus.txDone), 32'(!e));
                    check("crcOut", 32'(bus.crcOut), 32'(c));
                    check("xferCount", xferCnt, x);
                    check("readySeen", 32'(readySeen), 32'(x > 0));
                end
                acts.delete();
            end
        end
    end

    initial begin
        int t;
        bus.sendStart   = 1'b0;
        bus.sendPid     = 4'h0;
        bus.sendHasData = 1'b0;
        bus.sendLen     = 7'd0;
        reset = 1'b1;
        repeat (4) @(negedge useClk);
        reset = 1'b0;
        @(negedge useClk);
        check("rstOE", 32'(bus.OE), 32'd0);
        check("rstDPlus", 32'(bus.dPlus), 32'd1);
        check("rstDMinus", 32'(bus.dMinus), 32'd0);
        check("rstReady", 32'(bus.dataReady), 32'd0);
        check("rstBusy", 32'(bus.busy), 32'd0);
        check("rstDone", 32'(bus.txDone), 32'd0);
        check("rstError", 32'(bus.txError), 32'd0);
        check("rstCrc", 32'(bus.crcOut), 32'd0);

        startPacket(4'b0010, 1'b0, 0, 0, 1'b1);
        waitIdle();

        payload.delete();
        startPacket(4'b0011, 1'b1, 0, 0, 1'b1);
        waitIdle();

        payload = '{8'hFF, 8'hFF};
        startPacket(4'b1011, 1'b1, 2, 2, 1'b1);
        waitIdle();

        for (int p = 0; p < 8; p++) begin
            int len;
            len = (p == 0) ? 64 : int'($urandom_range(1, 64));
            randPayload(len);
            startPacket(($urandom % 2 == 0) ? 4'b0011 : 4'b1011,
                        1'b1, len, len, 1'b1);
            waitIdle();
        end

        randPayload(4);
        startPacket(4'b0011, 1'b1, 4, 2, 1'b1);
        waitIdle();

        randPayload(8);
        startPacket(4'b0011, 1'b1, 8, 8, 1'b0);
        t = 0;
        while (xferCnt < 3 && t < 5000) begin
            @(negedge useClk);
            t++;
        end
        check("midDataReached", 32'(xferCnt >= 3), 32'd1);
        repeat (5) @(negedge useClk);
        reset       = 1'b1;
        supplyLimit = 0;
        @(negedge useClk);
        reset = 1'b0;
        check("midRstOE", 32'(bus.OE), 32'd0);
        check("midRstDPlus", 32'(bus.dPlus), 32'd1);
        check("midRstDMinus", 32'(bus.dMinus), 32'd0);
        check("midRstBusy", 32'(bus.busy), 32'd0);
        check("midRstReady", 32'(bus.dataReady), 32'd0);
        check("midRstCrc", 32'(bus.crcOut), 32'd0);
        lastCrc = 16'h0000;
        repeat (3) @(negedge useClk);

        startPacket(4'b0010, 1'b0, 0, 0, 1'b1);
        waitIdle();

        randPayload(3);
        startPacket(4'b1011, 1'b1, 3, 3, 1'b1);
        repeat (30) @(negedge useClk);
        bus.sendStart   = 1'b1;
        bus.sendPid     = 4'b1010;
        bus.sendHasData = 1'b0;
        bus.sendLen     = 7'd0;
        @(negedge useClk);
        bus.sendStart = 1'b0;
        waitIdle();
        repeat (20) @(negedge useClk);
        check("busyAfterPoke", 32'(bus.busy), 32'd0);

        check("pendingPackets", expLen.size(), 0);
        check("doneTotal", doneCnt, wantDone);
        check("errorTotal", errCnt, wantErr);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
